// File: rtl/gpio_pattern_monitor_if.sv
// Control/status bundle of gpio_pattern_monitor.
// Ports: table write, seq_len/start/abort in; verdict flags, step, elapsed out.
interface gpio_pattern_monitor_if #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 25000
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(TIMEOUT_CYCLES + 1);

  logic             exp_wr_en;
  logic [AW-1:0]    exp_wr_addr;
  logic [WIDTH-1:0] exp_wr_value;
  logic [WIDTH-1:0] exp_wr_mask;
  logic [LW-1:0]    seq_len;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic             cfg_err;
  logic [AW-1:0]    step;
  logic [EW-1:0]    elapsed;

  modport master (
    output exp_wr_en, exp_wr_addr, exp_wr_value, exp_wr_mask,
    output seq_len, start, abort,
    input  busy, done, pass, fail, timeout, cfg_err, step, elapsed
  );

  modport slave (
    input  exp_wr_en, exp_wr_addr, exp_wr_value, exp_wr_mask,
    input  seq_len, start, abort,
    output busy, done, pass, fail, timeout, cfg_err, step, elapsed
  );
endinterface

// File: rtl/gpio_pattern_monitor.sv
// Checks io_in walks a programmed sequence of masked patterns in budget.
// Ports: wb_clk_i, wb_rst_i (sync, high), io_in, bus (control/status).
module gpio_pattern_monitor #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [WIDTH-1:0]      io_in,
  gpio_pattern_monitor_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] val_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [AW-1:0]    step_q, step_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    el_q, el_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic             cfg_q, cfg_d;
  logic             done_q, done_d;
  logic             match;
  logic             last;

  assign match = ((io_in ^ val_q[step_q]) & mask_q[step_q]) == '0;
  assign last  = int'(step_q) == int'(len_q) - 1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    el_d    = el_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
            tmo_d  = 1'b0;
            cfg_d  = 1'b0;
            step_d = '0;
            el_d   = '0;
            cnt_d  = '0;
            len_d  = bus.seq_len;
            if (bus.seq_len == '0) begin
              state_d = DONE;
              pass_d  = 1'b1;
              done_d  = 1'b1;
            end else if (int'(bus.seq_len) > DEPTH) begin
              state_d = DONE;
              fail_d  = 1'b1;
              cfg_d   = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = ARMED;
            end
          end
        end
        ARMED: begin
          if (int'(el_q) < TIMEOUT_CYCLES)
            el_d = el_q + EW'(1);
          cnt_d = match ? cnt_q + CW'(1) : '0;
          // completion is checked first so it wins over budget expiry
          if (int'(cnt_d) == STABLE_CYCLES) begin
            cnt_d = '0;
            if (last) begin
              state_d = DONE;
              pass_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              step_d = step_q + AW'(1);
            end
          end else if (int'(el_q) == TIMEOUT_CYCLES - 1) begin
            state_d = DONE;
            fail_d  = 1'b1;
            tmo_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      el_q    <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cfg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      el_q    <= el_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
    end
  end

  // table is deliberately not reset; frozen while a sequence is armed
  always_ff @(posedge wb_clk_i) begin
    if (bus.exp_wr_en && state_q != ARMED) begin
      val_q[bus.exp_wr_addr]  <= bus.exp_wr_value;
      mask_q[bus.exp_wr_addr] <= bus.exp_wr_mask;
    end
  end

  assign bus.busy    = state_q == ARMED;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.timeout = tmo_q;
  assign bus.cfg_err = cfg_q;
  assign bus.step    = step_q;
  assign bus.elapsed = el_q;
endmodule
